// File: rtl/gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gate_ctrl_pkg
// Shared definitions for the gate controller slice: metadata and token-cost
// widths, bucket width, queue identifiers and the dispatch FSM encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package gate_ctrl_pkg;

  localparam int MD_W     = 9;               // metadata word carried per frame
  localparam int COST_W   = 7;               // token cost field of the RC/PTP FIFO
  localparam int RC_MD_W  = COST_W + MD_W;   // RC/PTP FIFO word: {cost, md}
  localparam int BUCKET_W = 10;              // token bucket occupancy width
  localparam int QID_W    = 2;

  localparam logic [QID_W-1:0] Q_TSN_EVEN = 2'd0;
  localparam logic [QID_W-1:0] Q_TSN_ODD  = 2'd1;
  localparam logic [QID_W-1:0] Q_RC       = 2'd2;
  localparam logic [QID_W-1:0] Q_BE       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } gc_state_e;

endpackage

// File: rtl/gc_token_bucket.sv
// -----------------------------------------------------------------------------
// gc_token_bucket
// Credit shaper for the RC/PTP queue. A free-running counter refills the
// bucket by TOKEN_INC every TOKEN_RATE_CYC clocks (saturating at TOKEN_MAX);
// a consume request removes the head frame's cost in the same cycle.
// Build option: GC_TOKEN_BUCKET_EN. When it is not defined the bucket and
// counter are not built and the queue is always reported eligible.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   cost_i      : token cost of the RC/PTP FIFO head
//   consume_i   : head is being dispatched this cycle, debit its cost
//   elig_o      : bucket holds at least cost_i tokens (cost 0 always passes)
// -----------------------------------------------------------------------------
module gc_token_bucket
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned TOKEN_RATE_CYC = 8,
  parameter int unsigned TOKEN_INC      = 1,
  parameter int unsigned TOKEN_MAX      = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COST_W-1:0] cost_i,
  input  logic              consume_i,
  output logic              elig_o
);

`ifdef GC_TOKEN_BUCKET_EN

  localparam int CNT_W = (TOKEN_RATE_CYC > 1) ? $clog2(TOKEN_RATE_CYC) : 1;
  // Two spare bits so refill-before-clamp cannot wrap.
  localparam int SUM_W = BUCKET_W + 2;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUCKET_W-1:0] bucket_q, bucket_d;
  logic                wrap;
  logic                take;
  logic [SUM_W-1:0]    sum;

  always_comb begin
    elig_o = (bucket_q >= BUCKET_W'(cost_i));
    // Only debit when the head is affordable, so the bucket cannot underflow.
    take   = consume_i & elig_o;
    wrap   = (cnt_q == CNT_W'(TOKEN_RATE_CYC - 1));
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    sum    = SUM_W'(bucket_q)
           + (wrap ? SUM_W'(TOKEN_INC) : '0)
           - (take ? SUM_W'(cost_i) : '0);
    // Refill and debit combine before the clamp: min(b + inc - cost, max).
    if (sum > SUM_W'(TOKEN_MAX)) begin
      bucket_d = BUCKET_W'(TOKEN_MAX);
    end else begin
      bucket_d = sum[BUCKET_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bucket_q <= BUCKET_W'(TOKEN_MAX);
    end else begin
      cnt_q    <= cnt_d;
      bucket_q <= bucket_d;
    end
  end

`else

  // No shaping: the RC/PTP queue is gated only by its empty flag.
  assign elig_o = 1'b1;

  logic unused_ok;
  assign unused_ok = (^{clk, rst_n, cost_i, consume_i})
                   ^ ((TOKEN_RATE_CYC + TOKEN_INC + TOKEN_MAX + BUCKET_W) == 0);

`endif

endmodule

// File: rtl/gate_ctrl.sv
// -----------------------------------------------------------------------------
// gate_ctrl
// Time-slot gate controller. Picks one frame descriptor at a time from four
// show-ahead FIFOs and hands it to the transmitter:
//   eligible TSN queue > RC/PTP queue (token shaped) > best-effort queue.
// The eligible TSN queue is the one filled during the previous slot: q1 while
// the slot flag is 0 (even slot), q0 while it is 1 (odd slot).
// Dispatch FSM IDLE -> ISSUE -> HOLD -> IDLE: the decision is taken in IDLE
// and registered, so the pop strobe and the md/qid/wr outputs appear together
// in ISSUE; HOLD gives the FIFO a cycle to present its next head, so two
// dispatches are always separated by two strobe-free cycles.
// Build option: GC_TOKEN_BUCKET_EN enables RC/PTP token shaping.
//
// Ports
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_gc_time_slot_flag         : slot parity (0 even, 1 odd)
//   in_gc_q0/q1/q3_md, _empty    : TSN even / TSN odd / best-effort FIFO heads
//   in_gc_q2_md, in_gc_q2_empty  : RC/PTP FIFO head, [15:9] cost, [8:0] md
//   out_gc_q0_rd..out_gc_q3_rd   : one-cycle FIFO pop strobes
//   in_gc_tx_rdy                 : transmitter can take one descriptor
//   out_gc_md, _md_wr, _md_qid   : dispatched md, write strobe, source queue
// -----------------------------------------------------------------------------
module gate_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter string       PLATFORM       = "xilinx",
  parameter int unsigned TOKEN_RATE_CYC = 8,
  parameter int unsigned TOKEN_INC      = 1,
  parameter int unsigned TOKEN_MAX      = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_gc_time_slot_flag,
  input  logic [MD_W-1:0]    in_gc_q0_md,
  input  logic               in_gc_q0_empty,
  input  logic [MD_W-1:0]    in_gc_q1_md,
  input  logic               in_gc_q1_empty,
  input  logic [RC_MD_W-1:0] in_gc_q2_md,
  input  logic               in_gc_q2_empty,
  input  logic [MD_W-1:0]    in_gc_q3_md,
  input  logic               in_gc_q3_empty,
  output logic               out_gc_q0_rd,
  output logic               out_gc_q1_rd,
  output logic               out_gc_q2_rd,
  output logic               out_gc_q3_rd,
  input  logic               in_gc_tx_rdy,
  output logic [MD_W-1:0]    out_gc_md,
  output logic               out_gc_md_wr,
  output logic [QID_W-1:0]   out_gc_md_qid
);

  gc_state_e         state_q, state_d;
  logic [3:0]        rd_q, rd_d;
  logic              md_wr_q, md_wr_d;
  logic [MD_W-1:0]   md_q, md_d;
  logic [QID_W-1:0]  qid_q, qid_d;

  logic              tsn_empty;
  logic [MD_W-1:0]   tsn_md;
  logic [QID_W-1:0]  tsn_qid;
  logic              rc_tok_ok;
  logic              rc_consume;

  logic unused_platform;
  assign unused_platform = (PLATFORM == "");

  gc_token_bucket #(
    .TOKEN_RATE_CYC (TOKEN_RATE_CYC),
    .TOKEN_INC      (TOKEN_INC),
    .TOKEN_MAX      (TOKEN_MAX)
  ) u_bucket (
    .clk       (clk),
    .rst_n     (rst_n),
    .cost_i    (in_gc_q2_md[RC_MD_W-1:MD_W]),
    .consume_i (rc_consume),
    .elig_o    (rc_tok_ok)
  );

  always_comb begin
    // Serve the queue that filled during the previous slot; the other TSN
    // queue is still being filled and must not be touched.
    if (in_gc_time_slot_flag) begin
      tsn_empty = in_gc_q0_empty;
      tsn_md    = in_gc_q0_md;
      tsn_qid   = Q_TSN_EVEN;
    end else begin
      tsn_empty = in_gc_q1_empty;
      tsn_md    = in_gc_q1_md;
      tsn_qid   = Q_TSN_ODD;
    end

    state_d    = state_q;
    rd_d       = '0;
    md_wr_d    = 1'b0;
    md_d       = '0;
    qid_d      = '0;
    rc_consume = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The registered outputs are the latched selection: later slot-flag
        // or FIFO changes cannot alter a dispatch already in flight.
        if (in_gc_tx_rdy) begin
          if (!tsn_empty) begin
            state_d = ST_ISSUE;
            md_wr_d = 1'b1;
            md_d    = tsn_md;
            qid_d   = tsn_qid;
          end else if (!in_gc_q2_empty && rc_tok_ok) begin
            state_d    = ST_ISSUE;
            md_wr_d    = 1'b1;
            md_d       = in_gc_q2_md[MD_W-1:0];
            qid_d      = Q_RC;
            rc_consume = 1'b1;
          end else if (!in_gc_q3_empty) begin
            state_d = ST_ISSUE;
            md_wr_d = 1'b1;
            md_d    = in_gc_q3_md;
            qid_d   = Q_BE;
          end
          rd_d = md_wr_d ? (4'b0001 << qid_d) : 4'b0000;
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      md_wr_q <= 1'b0;
      md_q    <= '0;
      qid_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      md_wr_q <= md_wr_d;
      md_q    <= md_d;
      qid_q   <= qid_d;
    end
  end

  assign out_gc_q0_rd  = rd_q[0];
  assign out_gc_q1_rd  = rd_q[1];
  assign out_gc_q2_rd  = rd_q[2];
  assign out_gc_q3_rd  = rd_q[3];
  assign out_gc_md_wr  = md_wr_q;
  assign out_gc_md     = md_q;
  assign out_gc_md_qid = qid_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_ctrl
// Directed scenarios followed by randomized traffic for gate_ctrl. The four
// FIFOs are bench queues; a transaction-level reference model predicts, for
// every cycle, which pop strobe and descriptor the controller shows.
// Honours GC_TOKEN_BUCKET_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_gate_ctrl;

  localparam int RATE = 8;
  localparam int INC  = 1;
  localparam int TMAX = 1023;
`ifdef GC_TOKEN_BUCKET_EN
  localparam bit BKT = 1'b1;
`else
  localparam bit BKT = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag  = 1'b0;
  logic        rdy   = 1'b0;
  logic [8:0]  q0_md = '0, q1_md = '0, q3_md = '0;
  logic [15:0] q2_md = '0;
  logic        q0_e = 1'b1, q1_e = 1'b1, q2_e = 1'b1, q3_e = 1'b1;
  logic        q0_rd, q1_rd, q2_rd, q3_rd;
  logic        md_wr;
  logic [8:0]  md;
  logic [1:0]  qid;

  gate_ctrl #(
    .PLATFORM       ("xilinx"),
    .TOKEN_RATE_CYC (RATE),
    .TOKEN_INC      (INC),
    .TOKEN_MAX      (TMAX)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_gc_time_slot_flag (flag),
    .in_gc_q0_md          (q0_md),
    .in_gc_q0_empty       (q0_e),
    .in_gc_q1_md          (q1_md),
    .in_gc_q1_empty       (q1_e),
    .in_gc_q2_md          (q2_md),
    .in_gc_q2_empty       (q2_e),
    .in_gc_q3_md          (q3_md),
    .in_gc_q3_empty       (q3_e),
    .out_gc_q0_rd         (q0_rd),
    .out_gc_q1_rd         (q1_rd),
    .out_gc_q2_rd         (q2_rd),
    .out_gc_q3_rd         (q3_rd),
    .in_gc_tx_rdy         (rdy),
    .out_gc_md            (md),
    .out_gc_md_wr         (md_wr),
    .out_gc_md_qid        (qid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Bench FIFOs; q2 entries are {cost, md}.
  logic [15:0] f0[$], f1[$], f2[$], f3[$];

  // Reference model: cycles until a new decision may be taken, token count,
  // clocks since reset, and the outputs expected in the current cycle.
  int         busy;
  int         bucket;
  int         cyc;
  logic [3:0] e_rd;
  logic       e_wr;
  logic [8:0] e_md;
  logic [1:0] e_qid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int q);
    case (q)
      0:       return f0.size();
      1:       return f1.size();
      2:       return f2.size();
      default: return f3.size();
    endcase
  endfunction

  function automatic logic [15:0] head(input int q);
    logic [15:0] h;
    h = '0;
    if (qsize(q) != 0) begin
      case (q)
        0:       h = f0[0];
        1:       h = f1[0];
        2:       h = f2[0];
        default: h = f3[0];
      endcase
    end
    return h;
  endfunction

  task automatic drive_fifos();
    logic [15:0] h;
    h = head(0); q0_md = h[8:0]; q0_e = (qsize(0) == 0);
    h = head(1); q1_md = h[8:0]; q1_e = (qsize(1) == 0);
    h = head(2); q2_md = h;      q2_e = (qsize(2) == 0);
    h = head(3); q3_md = h[8:0]; q3_e = (qsize(3) == 0);
  endtask

  task automatic push(input int q, input logic [15:0] v);
    case (q)
      0:       f0.push_back(v);
      1:       f1.push_back(v);
      2:       f2.push_back(v);
      default: f3.push_back(v);
    endcase
    drive_fifos();
  endtask

  task automatic pop(input int q);
    logic [15:0] d;
    d = '0;
    if (qsize(q) != 0) begin
      case (q)
        0:       d = f0.pop_front();
        1:       d = f1.pop_front();
        2:       d = f2.pop_front();
        default: d = f3.pop_front();
      endcase
    end
    drive_fifos();
  endtask

  task automatic model_reset();
    busy   = 0;
    bucket = TMAX;
    cyc    = 0;
    e_rd   = '0;
    e_wr   = 1'b0;
    e_md   = '0;
    e_qid  = '0;
  endtask

  // One clock: check the current cycle at the falling edge, predict the
  // decision taken at the coming rising edge, commit it 1 time unit later.
  task automatic step();
    logic [3:0]  n_rd;
    logic        n_wr;
    logic [8:0]  n_md;
    logic [1:0]  n_qid;
    logic [15:0] h;
    int          n_busy, cost_used, tsn;
    bit          refill;
    @(negedge clk);
    chk("strobes", {11'b0, q3_rd, q2_rd, q1_rd, q0_rd, md_wr}, {11'b0, e_rd, e_wr});
    chk("data", {5'b0, qid, md}, {5'b0, e_qid, e_md});
    n_rd = '0; n_wr = 1'b0; n_md = '0; n_qid = '0; cost_used = 0;
    n_busy = (busy > 0) ? busy - 1 : 0;
    if (busy == 0 && rdy) begin
      tsn = flag ? 0 : 1;
      if (qsize(tsn) != 0) begin
        h = head(tsn); n_wr = 1'b1; n_qid = 2'(tsn); n_md = h[8:0];
      end else if (qsize(2) != 0 && (!BKT || int'(head(2) >> 9) <= bucket)) begin
        h = head(2); n_wr = 1'b1; n_qid = 2'd2; n_md = h[8:0];
        cost_used = BKT ? int'(h >> 9) : 0;
      end else if (qsize(3) != 0) begin
        h = head(3); n_wr = 1'b1; n_qid = 2'd3; n_md = h[8:0];
      end
      if (n_wr) begin
        n_rd   = 4'b0001 << n_qid;
        n_busy = 2;
      end
    end
    refill = ((cyc % RATE) == RATE - 1);
    @(posedge clk);
    #1;
    if (e_wr) pop(int'(e_qid));
    if (BKT) begin
      bucket = bucket + (refill ? INC : 0) - cost_used;
      if (bucket > TMAX) bucket = TMAX;
    end
    cyc++;
    busy  = n_busy;
    e_rd  = n_rd;
    e_wr  = n_wr;
    e_md  = n_md;
    e_qid = n_qid;
  endtask

  task automatic run_to_wr(input int budget, output logic [1:0] oq,
                           output logic [8:0] om, output int n);
    bit found;
    found = 1'b0; oq = '0; om = '0; n = 0;
    while (!found && n < budget) begin
      step();
      n++;
      if (md_wr === 1'b1) begin
        found = 1'b1; oq = qid; om = md;
      end
    end
    chk("dispatch_seen", {15'b0, found}, 16'd1);
  endtask

  task automatic settle();
    for (int i = 0; i < 6 && busy != 0; i++) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rdy = 1'b1;
    while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) != 0 && n < budget) begin
      if (n % 8 == 7) flag = ~flag;
      step();
      n++;
    end
    chk("drain_empty", 16'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 16'd0);
  endtask

  initial begin
    logic [1:0] oq;
    logic [8:0] om;
    int         n, cnt, c;

    model_reset();
    drive_fifos();
    #1;
    chk("rst_strobes", {11'b0, q3_rd, q2_rd, q1_rd, q0_rd, md_wr}, 16'd0);
    chk("rst_data", {5'b0, qid, md}, 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Even slot: only q1 may be served, q0 waits for the odd slot.
    flag = 1'b0; rdy = 1'b1;
    push(0, 16'h00AA); push(1, 16'h0015);
    run_to_wr(4, oq, om, n);
    chk("s1_qid", {14'b0, oq}, 16'd1);
    chk("s1_md", {7'b0, om}, 16'h0015);
    chk("s1_latency", 16'(n), 16'd1);
    repeat (6) step();
    flag = 1'b1;
    run_to_wr(6, oq, om, n);
    chk("s1_odd_qid", {14'b0, oq}, 16'd0);
    chk("s1_odd_md", {7'b0, om}, 16'h00AA);

    // RC before best effort, then two strobe-free cycles before the next.
    settle();
    push(2, {7'd7, 9'h102}); push(3, 16'h0033);
    run_to_wr(4, oq, om, n);
    chk("s2_rc_qid", {14'b0, oq}, 16'd2);
    chk("s2_rc_md", {7'b0, om}, 16'h0102);
    run_to_wr(6, oq, om, n);
    chk("s2_be_qid", {14'b0, oq}, 16'd3);
    chk("s2_spacing", 16'(n), 16'd3);

    // Starve the RC queue: best effort overtakes until refill covers cost 5.
    settle();
`ifdef GC_TOKEN_BUCKET_EN
    for (int k = 0; k < 20 && bucket != 3; k++) begin
      settle();
      c = bucket + (((cyc % RATE) == RATE - 1) ? INC : 0) - 3;
      if (c > 127) c = 127;
      push(2, {7'(c), 9'(k)});
      run_to_wr(4, oq, om, n);
      chk("s3_drain_qid", {14'b0, oq}, 16'd2);
    end
    settle();
`endif
    push(2, {7'd5, 9'h155}); push(3, 16'h00E3);
    run_to_wr(4, oq, om, n);
`ifdef GC_TOKEN_BUCKET_EN
    chk("s3_first_qid", {14'b0, oq}, 16'd3);
`else
    chk("s3_first_qid", {14'b0, oq}, 16'd2);
`endif
    run_to_wr(40, oq, om, n);
`ifdef GC_TOKEN_BUCKET_EN
    chk("s3_second_qid", {14'b0, oq}, 16'd2);
    chk("s3_second_md", {7'b0, om}, 16'h0155);
`else
    chk("s3_second_qid", {14'b0, oq}, 16'd3);
`endif

    // Zero-cost PTP frame goes out even with an empty bucket.
    settle();
    push(2, {7'd0, 9'h1A0}); push(3, 16'h0077);
    run_to_wr(4, oq, om, n);
    chk("s4_ptp_qid", {14'b0, oq}, 16'd2);
    chk("s4_ptp_md", {7'b0, om}, 16'h01A0);
    chk("s4_latency", 16'(n), 16'd1);
    run_to_wr(6, oq, om, n);
    chk("s4_be_qid", {14'b0, oq}, 16'd3);

    // Transmitter not ready: nothing moves; then TSN goes first.
    settle();
    rdy = 1'b0; flag = 1'b0;
    push(0, 16'h0100); push(1, 16'h0101); push(2, {7'd0, 9'h102}); push(3, 16'h0103);
    cnt = 0;
    repeat (20) begin
      step();
      if ({q0_rd, q1_rd, q2_rd, q3_rd, md_wr} != 5'b0) cnt++;
    end
    chk("s5_quiet", 16'(cnt), 16'd0);
    rdy = 1'b1;
    run_to_wr(4, oq, om, n);
    chk("s5_tsn_qid", {14'b0, oq}, 16'd1);
    chk("s5_tsn_md", {7'b0, om}, 16'h0101);
    chk("s5_latency", 16'(n), 16'd1);
    drain(100);

    // Reset in the middle of an ISSUE cycle.
    settle();
    flag = 1'b0;
    push(1, 16'h0011);
    run_to_wr(4, oq, om, n);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_strobes", {11'b0, q3_rd, q2_rd, q1_rd, q0_rd, md_wr}, 16'd0);
    chk("s6_rst_data", {5'b0, qid, md}, 16'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    flag = 1'b1;
    push(2, {7'd100, 9'h0C8}); push(3, 16'h00D3);
    run_to_wr(4, oq, om, n);
    chk("s6_full_bucket_qid", {14'b0, oq}, 16'd2);
    chk("s6_full_bucket_md", {7'b0, om}, 16'h00C8);
    flag = 1'b0;
    drain(200);

    // Randomized traffic with slot flips and back-pressure.
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) flag = ~flag;
      if ($urandom_range(0, 3) == 0 && qsize(0) < 8) push(0, 16'($urandom_range(0, 511)));
      if ($urandom_range(0, 3) == 0 && qsize(1) < 8) push(1, 16'($urandom_range(0, 511)));
      if ($urandom_range(0, 4) == 0 && qsize(2) < 8) begin
        c = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40));
        push(2, {7'(c), 9'($urandom_range(0, 511))});
      end
      if ($urandom_range(0, 3) == 0 && qsize(3) < 8) push(3, 16'($urandom_range(0, 511)));
      step();
    end
    drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
